// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the hazard scoreboard: stage indices,
// forwarding code encodings and the tracker entry tag.
package hazard_scoreboard_pkg;

  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;

  // Forwarding code 0 selects the register file; code k selects the
  // output register of stage k.
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic valid;
    logic is_load;
  } trk_tag_t;

  function automatic int stg_wb(input int depth);
    return depth;
  endfunction

  function automatic int fwd_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // First stage whose output register holds the producer's result.
  function automatic int ready_stage(input logic is_load, input int load_lat);
    return is_load ? (STG_EX + load_lat) : STG_EX;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard/forwarding response bundle.
// Handshake: no valid/ready; id_* are sampled every cycle, stall answers combinationally.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int FWD_W  = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_wr;
  logic              id_is_load;
  logic              br_taken;
  logic              stall;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic [FWD_W-1:0]  ex_fwd_a;
  logic [FWD_W-1:0]  ex_fwd_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr,
           id_is_load, br_taken,
    input  stall, pc_write, ifid_write, ifid_flush, ex_fwd_a, ex_fwd_b,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr,
           id_is_load, br_taken,
    output stall, pc_write, ifid_write, ifid_flush, ex_fwd_a, ex_fwd_b,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_tracker_stage.sv
// One in-flight writer slot of the tracker shift register.
module hazard_tracker_stage
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  trk_tag_t      in_tag,
  input  logic [AW-1:0] in_rd,
  output trk_tag_t      out_tag,
  output logic [AW-1:0] out_rd
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_tag <= '0;
      out_rd  <= '0;
    end else begin
      out_tag.valid   <= in_tag.valid;
      out_tag.is_load <= in_tag.valid & in_tag.is_load;
      out_rd          <= in_rd;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Depth/latency-generic stall and forwarding controller beside the ID stage,
// with saturating stall and flush event counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);

  localparam int FWD_W = fwd_width(DEPTH);

  trk_tag_t          tag_d [1:DEPTH];
  trk_tag_t          tag_q [1:DEPTH];
  logic [REG_AW-1:0] rd_d  [1:DEPTH];
  logic [REG_AW-1:0] rd_q  [1:DEPTH];

  logic [DEPTH:1]    hit_a;
  logic [DEPTH:1]    hit_b;
  logic              stall_c;
  logic              issue;
  logic [FWD_W-1:0]  fwd_a_c;
  logic [FWD_W-1:0]  fwd_b_c;
  logic [FWD_W-1:0]  fwd_a_q;
  logic [FWD_W-1:0]  fwd_b_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  assign issue = bus.id_valid & ~stall_c;

  // A stalled or non-writing instruction enters EX as a bubble.
  assign tag_d[1].valid   = issue & bus.id_wr & (bus.id_rd != '0);
  assign tag_d[1].is_load = bus.id_is_load;
  assign rd_d[1]          = bus.id_rd;

  for (genvar g = 1; g <= DEPTH; g++) begin : g_stage
    if (g > 1) begin : g_link
      assign tag_d[g] = tag_q[g-1];
      assign rd_d[g]  = rd_q[g-1];
    end
    hazard_tracker_stage #(.AW(REG_AW)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .in_tag  (tag_d[g]),
      .in_rd   (rd_d[g]),
      .out_tag (tag_q[g]),
      .out_rd  (rd_q[g])
    );
  end

  always_comb begin
    hit_a   = '0;
    hit_b   = '0;
    stall_c = 1'b0;
    fwd_a_c = '0;
    fwd_b_c = '0;
    for (int s = 1; s <= DEPTH; s++) begin
      hit_a[s] = bus.id_use_rs && tag_q[s].valid && (rd_q[s] == bus.id_rs) && (bus.id_rs != '0);
      hit_b[s] = bus.id_use_rt && tag_q[s].valid && (rd_q[s] == bus.id_rt) && (bus.id_rt != '0);
      if ((hit_a[s] || hit_b[s]) && (s < ready_stage(tag_q[s].is_load, LOAD_LAT)))
        stall_c = 1'b1;
    end
    stall_c = stall_c & bus.id_valid & ~rst;
    // Walk oldest to youngest so the youngest match is the last writer.
    // The WB stage is excluded: the register file is write-first.
    for (int s = DEPTH - 1; s >= 1; s--) begin
      if (hit_a[s]) fwd_a_c = FWD_W'(s);
      if (hit_b[s]) fwd_b_c = FWD_W'(s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fwd_a_q <= issue ? fwd_a_c : '0;
      fwd_b_q <= issue ? fwd_b_c : '0;
      if (stall_c && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (bus.br_taken && !stall_c && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall      = stall_c;
  assign bus.pc_write   = ~stall_c;
  assign bus.ifid_write = ~stall_c;
  assign bus.ifid_flush = bus.br_taken & ~stall_c & ~rst;
  assign bus.ex_fwd_a   = fwd_a_q;
  assign bus.ex_fwd_b   = fwd_b_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard (DEPTH=3, LOAD_LAT=1, CNT_W=4) against an
// age-list reference model of in-flight writers.
module tb_hazard_scoreboard;

  localparam int REG_AW   = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int CNT_W    = 4;
  localparam int FWD_W    = 2;

  logic clk;
  logic rst;

  hazard_scoreboard_if #(.REG_AW(REG_AW), .FWD_W(FWD_W), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: list of writers with their age in cycles since issue.
  typedef struct {
    int rd;
    bit ld;
    int age;
  } wr_t;
  wr_t mq[$];

  logic             e_stall, e_flush;
  logic [FWD_W-1:0] nf_a, nf_b, e_fa, e_fb;
  logic [CNT_W-1:0] e_sc, e_fc;

  logic             o_stall, o_pcw, o_ifw, o_flush;
  logic [FWD_W-1:0] o_fa, o_fb;
  logic [CNT_W-1:0] o_sc, o_fc;

  function automatic void model_comb();
    bit any = 0;
    int ca = 0, cb = 0;
    foreach (mq[i]) begin
      int  ready = mq[i].ld ? 1 + LOAD_LAT : 1;
      bit  ma = bus.id_use_rs && (bus.id_rs != 0) && (mq[i].rd == int'(bus.id_rs));
      bit  mb = bus.id_use_rt && (bus.id_rt != 0) && (mq[i].rd == int'(bus.id_rt));
      if ((ma || mb) && mq[i].age < ready) any = 1;
      if (ma && mq[i].age < DEPTH && (ca == 0 || mq[i].age < ca)) ca = mq[i].age;
      if (mb && mq[i].age < DEPTH && (cb == 0 || mq[i].age < cb)) cb = mq[i].age;
    end
    e_stall = !rst && bus.id_valid && any;
    e_flush = !rst && bus.br_taken && !e_stall;
    nf_a = FWD_W'(ca);
    nf_b = FWD_W'(cb);
  endfunction

  function automatic void model_clock();
    bit iss;
    if (rst) begin
      mq.delete();
      e_fa = '0; e_fb = '0; e_sc = '0; e_fc = '0;
      return;
    end
    iss = bus.id_valid && !e_stall;
    e_fa = iss ? nf_a : '0;
    e_fb = iss ? nf_b : '0;
    if (e_stall && e_sc != '1) e_sc = e_sc + 1'b1;
    if (e_flush && e_fc != '1) e_fc = e_fc + 1'b1;
    foreach (mq[i]) mq[i].age++;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].age > DEPTH) mq.delete(i);
    if (iss && bus.id_wr && bus.id_rd != 0)
      mq.push_back('{rd: int'(bus.id_rd), ld: bus.id_is_load, age: 1});
  endfunction

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int rd, input bit wr, input bit ld, input bit br);
    bus.id_valid   = v;
    bus.id_rs      = REG_AW'(rs);
    bus.id_rt      = REG_AW'(rt);
    bus.id_use_rs  = urs;
    bus.id_use_rt  = urt;
    bus.id_rd      = REG_AW'(rd);
    bus.id_wr      = wr;
    bus.id_is_load = ld;
    bus.br_taken   = br;
  endtask

  // Sample combinational outputs mid-cycle, then registered outputs after the edge.
  task automatic tick();
    @(negedge clk);
    model_comb();
    o_stall = bus.stall; o_pcw = bus.pc_write; o_ifw = bus.ifid_write; o_flush = bus.ifid_flush;
    @(posedge clk);
    model_clock();
    #1;
    o_fa = bus.ex_fwd_a; o_fb = bus.ex_fwd_b; o_sc = bus.stall_cnt; o_fc = bus.flush_cnt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_vec += 8;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", o_stall); end
    if (o_pcw !== 1'b1) begin n_err++; $display("FAIL reset_pc_write got %b want 1", o_pcw); end
    if (o_ifw !== 1'b1) begin n_err++; $display("FAIL reset_ifid_write got %b want 1", o_ifw); end
    if (o_flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %b want 0", o_flush); end
    if (o_fa !== 2'd0) begin n_err++; $display("FAIL reset_fwd_a got %0d want 0", o_fa); end
    if (o_fb !== 2'd0) begin n_err++; $display("FAIL reset_fwd_b got %0d want 0", o_fb); end
    if (o_sc !== 4'd0) begin n_err++; $display("FAIL reset_stall_cnt got %0d want 0", o_sc); end
    if (o_fc !== 4'd0) begin n_err++; $display("FAIL reset_flush_cnt got %0d want 0", o_fc); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    set_id(1, 3, 0, 1, 0, 4, 1, 0, 0); tick();
    n_vec += 3;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL alu_fwd_stall got %b want 0", o_stall); end
    if (o_fa !== 2'd1) begin n_err++; $display("FAIL alu_fwd_a got %0d want 1", o_fa); end
    if (o_fb !== 2'd0) begin n_err++; $display("FAIL alu_fwd_b got %0d want 0", o_fb); end
  endtask

  task automatic test_fwd_b_dist2();
    do_reset();
    set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    set_id(1, 1, 2, 1, 1, 9, 1, 0, 0); tick();
    set_id(1, 0, 3, 0, 1, 4, 1, 0, 0); tick();
    n_vec += 2;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL dist2_stall got %b want 0", o_stall); end
    if (o_fb !== 2'd2) begin n_err++; $display("FAIL dist2_fwd_b got %0d want 2", o_fb); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    set_id(1, 5, 0, 1, 0, 6, 1, 0, 0); tick();
    n_vec += 3;
    if (o_stall !== 1'b1) begin n_err++; $display("FAIL load_use_stall got %b want 1", o_stall); end
    if (o_pcw !== 1'b0) begin n_err++; $display("FAIL load_use_pc_write got %b want 0", o_pcw); end
    if (o_fa !== 2'd0) begin n_err++; $display("FAIL load_use_bubble_fwd got %0d want 0", o_fa); end
    tick();
    n_vec += 3;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL load_use_release got %b want 0", o_stall); end
    if (o_fa !== 2'd2) begin n_err++; $display("FAIL load_use_fwd_a got %0d want 2", o_fa); end
    if (o_sc !== 4'd1) begin n_err++; $display("FAIL load_use_stall_cnt got %0d want 1", o_sc); end
  endtask

  task automatic test_r0();
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    set_id(1, 0, 0, 1, 1, 0, 1, 1, 0); tick();
    set_id(1, 0, 0, 1, 1, 4, 1, 0, 0); tick();
    n_vec += 3;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL r0_stall got %b want 0", o_stall); end
    if (o_fa !== 2'd0) begin n_err++; $display("FAIL r0_fwd_a got %0d want 0", o_fa); end
    if (o_fb !== 2'd0) begin n_err++; $display("FAIL r0_fwd_b got %0d want 0", o_fb); end
  endtask

  task automatic test_branch();
    do_reset();
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 1); tick();
    n_vec += 3;
    if (o_flush !== 1'b1) begin n_err++; $display("FAIL branch_flush got %b want 1", o_flush); end
    if (o_pcw !== 1'b1) begin n_err++; $display("FAIL branch_pc_write got %b want 1", o_pcw); end
    if (o_fc !== 4'd1) begin n_err++; $display("FAIL branch_flush_cnt got %0d want 1", o_fc); end
  endtask

  task automatic test_dep_branch();
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 0); tick();
    set_id(1, 7, 7, 1, 1, 0, 0, 0, 1); tick();
    n_vec += 4;
    if (o_stall !== 1'b1) begin n_err++; $display("FAIL dep_branch_stall got %b want 1", o_stall); end
    if (o_flush !== 1'b0) begin n_err++; $display("FAIL dep_branch_flush got %b want 0", o_flush); end
    if (o_ifw !== 1'b0) begin n_err++; $display("FAIL dep_branch_ifid_write got %b want 0", o_ifw); end
    if (o_fc !== 4'd0) begin n_err++; $display("FAIL dep_branch_flush_cnt got %0d want 0", o_fc); end
    tick();
    n_vec += 3;
    if (o_flush !== 1'b1) begin n_err++; $display("FAIL dep_branch_late_flush got %b want 1", o_flush); end
    if (o_fc !== 4'd1) begin n_err++; $display("FAIL dep_branch_late_cnt got %0d want 1", o_fc); end
    if (o_sc !== 4'd1) begin n_err++; $display("FAIL dep_branch_stall_cnt got %0d want 1", o_sc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    rst = 1'b0;
    set_id(1, 5, 0, 1, 0, 6, 1, 0, 0); tick();
    n_vec += 4;
    if (o_stall !== 1'b0) begin n_err++; $display("FAIL reset_mid_stall got %b want 0", o_stall); end
    if (o_fa !== 2'd0) begin n_err++; $display("FAIL reset_mid_fwd_a got %0d want 0", o_fa); end
    if (o_sc !== 4'd0) begin n_err++; $display("FAIL reset_mid_stall_cnt got %0d want 0", o_sc); end
    if (o_fc !== 4'd0) begin n_err++; $display("FAIL reset_mid_flush_cnt got %0d want 0", o_fc); end
  endtask

  // Chain of loads each reading the previous one: stalls every other cycle.
  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      set_id(1, 5, 0, 1, 0, 5, 1, 1, 0); tick();
      n_vec += 2;
      if (o_stall !== e_stall) begin n_err++; $display("FAIL sat_stall[%0d] got %b want %b", i, o_stall, e_stall); end
      if (o_sc !== e_sc) begin n_err++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, o_sc, e_sc); end
    end
    n_vec++;
    if (o_sc !== 4'd15) begin n_err++; $display("FAIL sat_final got %0d want 15", o_sc); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 40) == 0);
      set_id($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      tick();
      n_vec += 7;
      if (o_stall !== e_stall) begin n_err++; $display("FAIL rnd_stall[%0d] got %b want %b", i, o_stall, e_stall); end
      if (o_pcw !== !e_stall) begin n_err++; $display("FAIL rnd_pc_write[%0d] got %b want %b", i, o_pcw, !e_stall); end
      if (o_flush !== e_flush) begin n_err++; $display("FAIL rnd_flush[%0d] got %b want %b", i, o_flush, e_flush); end
      if (o_fa !== e_fa) begin n_err++; $display("FAIL rnd_fwd_a[%0d] got %0d want %0d", i, o_fa, e_fa); end
      if (o_fb !== e_fb) begin n_err++; $display("FAIL rnd_fwd_b[%0d] got %0d want %0d", i, o_fb, e_fb); end
      if (o_sc !== e_sc) begin n_err++; $display("FAIL rnd_stall_cnt[%0d] got %0d want %0d", i, o_sc, e_sc); end
      if (o_fc !== e_fc) begin n_err++; $display("FAIL rnd_flush_cnt[%0d] got %0d want %0d", i, o_fc, e_fc); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_fa = '0; e_fb = '0; e_sc = '0; e_fc = '0;
    test_reset();
    test_alu_fwd();
    test_fwd_b_dist2();
    test_load_use();
    test_r0();
    test_branch();
    test_dep_branch();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
